// File: rtl/gpio_link_pkg.sv
// gpio_link_pkg: constants and types shared by both ends of the 18-pin GPIO link.
//   Pin map  : [17] forwarded tx clock, [16] valid strobe, [15:0] data word.
//   Word 0   : [15] text-ready flag, [14] audio-ready flag, [7:0] text byte.
//   Frame    : three 16-bit words, sent in the order W0, W1, W2.
package gpio_link_pkg;

   localparam int unsigned TX_CLK_BIT    = 17;
   localparam int unsigned TX_VALID_BIT  = 16;
   localparam int unsigned TEXT_RDY_BIT  = 15;
   localparam int unsigned AUDIO_RDY_BIT = 14;
   localparam int unsigned FRAME_WORDS   = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      W0   = 2'd1,
      W1   = 2'd2,
      W2   = 2'd3
   } link_state_e;

   // Header word of a frame. The text field reads as zero when no text is carried.
   function automatic logic [15:0] make_word0(input logic       t_rdy,
                                              input logic       a_rdy,
                                              input logic [7:0] text);
      logic [15:0] w;
      w                = '0;
      w[TEXT_RDY_BIT]  = t_rdy;
      w[AUDIO_RDY_BIT] = a_rdy;
      w[7:0]           = t_rdy ? text : 8'h00;
      return w;
   endfunction

endpackage

// File: rtl/gpio_transmitter_text_fifo.sv
// text_fifo: synchronous first-word-fall-through FIFO, 8 bits wide.
//   clk, reset : system clock, synchronous active-high reset
//   push, din  : write strobe and data (accepted when not full, or when full
//                and popping in the same cycle)
//   pop, dout  : read strobe; dout always shows the head entry
//   full, empty: occupancy flags
module text_fifo #(
   parameter int unsigned DEPTH = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       push,
   input  logic       pop,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       full,
   output logic       empty
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   // Pointers carry one extra wrap bit so full and empty can be told apart.
   logic [AW:0] wr_q, rd_q;
   logic [7:0]  mem_q [DEPTH];
   logic        do_push, do_pop;

   assign empty   = (wr_q == rd_q);
   assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem_q[rd_q[AW-1:0]];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + 1'b1;
         if (do_pop)  rd_q <= rd_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q[AW-1:0]] <= din;
   end

endmodule

// File: rtl/gpio_transmitter.sv
// gpio_transmitter: buffers text bytes and audio samples and serialises them as
// three-word frames over an 18-pin GPIO bus with a forwarded, free-running clock.
//   FPGA_clock, reset : system clock, synchronous active-high reset
//   text_in/_ready_in : one-cycle push of a character into the text FIFO
//   audio_in/_ready_in: one-cycle strobe latching the latest audio sample
//   tx_pins           : [17] tx clock, [16] valid, [15:0] data word
//   busy              : frame in flight or data still buffered
//   text_overflow     : one-cycle pulse after a dropped text push
module gpio_transmitter
   import gpio_link_pkg::*;
#(
   parameter int unsigned CLK_HALF        = 4,
   parameter int unsigned GAP_PERIODS     = 2,
   parameter int unsigned TEXT_FIFO_DEPTH = 8
) (
   input  logic        FPGA_clock,
   input  logic        reset,
   input  logic [7:0]  text_in,
   input  logic        text_ready_in,
   input  logic [31:0] audio_in,
   input  logic        audio_ready_in,
   output logic [17:0] tx_pins,
   output logic        busy,
   output logic        text_overflow
);

   localparam int unsigned DW = $clog2(CLK_HALF);
   localparam int unsigned GW = $clog2(GAP_PERIODS + 1);

   logic [DW-1:0] div_q, div_d;
   logic          txclk_q;
   logic          valid_q;
   logic [15:0]   data_q;
   link_state_e   state_q;
   logic [GW-1:0] gap_q;
   logic          pend_q;
   logic [31:0]   audio_q;
   logic          fr_ardy_q;
   logic [31:0]   fr_audio_q;
   logic          ovf_q;

   logic          wrap, fall_tick, leave, fifo_pop;
   logic          fifo_full, fifo_empty;
   logic [7:0]    fifo_dout;

   text_fifo #(.DEPTH(TEXT_FIFO_DEPTH)) u_text_fifo (
      .clk   (FPGA_clock),
      .reset (reset),
      .push  (text_ready_in),
      .pop   (fifo_pop),
      .din   (text_in),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign wrap      = (div_q == DW'(CLK_HALF - 1));
   assign div_d     = wrap ? '0 : div_q + 1'b1;
   // The edge that drives the tx clock low is the only edge the frame logic uses.
   assign fall_tick = wrap && txclk_q;
   assign leave     = fall_tick && (state_q == IDLE) && (gap_q == GW'(GAP_PERIODS))
                      && (!fifo_empty || pend_q);
   assign fifo_pop  = leave && !fifo_empty;

   always_ff @(posedge FPGA_clock) begin
      if (reset) begin
         div_q   <= '0;
         txclk_q <= 1'b0;
      end else begin
         div_q <= div_d;
         if (wrap) txclk_q <= ~txclk_q;
      end
   end

   always_ff @(posedge FPGA_clock) begin
      if (reset) begin
         state_q    <= IDLE;
         gap_q      <= '0;
         valid_q    <= 1'b0;
         data_q     <= '0;
         fr_ardy_q  <= 1'b0;
         fr_audio_q <= '0;
         pend_q     <= 1'b0;
         audio_q    <= '0;
      end else begin
         if (fall_tick) begin
            unique case (state_q)
               IDLE: begin
                  if (leave) begin
                     // Word 0 goes out on the same edge as the snapshot is taken.
                     fr_ardy_q  <= pend_q;
                     fr_audio_q <= pend_q ? audio_q : '0;
                     valid_q    <= 1'b1;
                     data_q     <= make_word0(!fifo_empty, pend_q, fifo_dout);
                     state_q    <= W0;
                  end else if (gap_q != GW'(GAP_PERIODS)) begin
                     gap_q <= gap_q + 1'b1;
                  end
               end
               W0: begin
                  data_q  <= fr_audio_q[31:16];
                  state_q <= W1;
               end
               W1: begin
                  data_q  <= fr_audio_q[15:0];
                  state_q <= W2;
               end
               W2: begin
                  valid_q <= 1'b0;
                  data_q  <= '0;
                  gap_q   <= '0;
                  state_q <= IDLE;
               end
               default: state_q <= IDLE;
            endcase
         end
         // A new sample arriving on the snapshot edge stays pending (last write wins).
         if (leave && pend_q) pend_q <= 1'b0;
         if (audio_ready_in) begin
            audio_q <= audio_in;
            pend_q  <= 1'b1;
         end
      end
   end

   always_ff @(posedge FPGA_clock) begin
      if (reset) ovf_q <= 1'b0;
      else       ovf_q <= text_ready_in && fifo_full && !fifo_pop;
   end

   always_comb begin
      tx_pins               = '0;
      tx_pins[TX_CLK_BIT]   = txclk_q;
      tx_pins[TX_VALID_BIT] = valid_q;
      tx_pins[15:0]         = data_q;
   end

   assign busy          = (state_q != IDLE) || !fifo_empty || pend_q;
   assign text_overflow = ovf_q;

endmodule

// File: tb/tb_gpio_transmitter.sv
// Directed bench for gpio_transmitter: a pin monitor captures each word on the
// rising tx clock while valid is high and checks frame and gap lengths.
module tb_gpio_transmitter;

   localparam int CLK_HALF = 4;

   logic        FPGA_clock = 1'b0;
   logic        reset;
   logic [7:0]  text_in;
   logic        text_ready_in;
   logic [31:0] audio_in;
   logic        audio_ready_in;
   logic [17:0] tx_pins;
   logic        busy;
   logic        text_overflow;

   int n_cmp = 0;
   int n_bad = 0;

   gpio_transmitter #(
      .CLK_HALF        (4),
      .GAP_PERIODS     (2),
      .TEXT_FIFO_DEPTH (8)
   ) dut (
      .FPGA_clock     (FPGA_clock),
      .reset          (reset),
      .text_in        (text_in),
      .text_ready_in  (text_ready_in),
      .audio_in       (audio_in),
      .audio_ready_in (audio_ready_in),
      .tx_pins        (tx_pins),
      .busy           (busy),
      .text_overflow  (text_overflow)
   );

   always #5 FPGA_clock = ~FPGA_clock;

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // ---------------- pin monitor ----------------
   logic [15:0] words [0:255];
   int unsigned wr_cnt     = 0;
   logic        prev_clk   = 1'b0;
   logic        prev_valid = 1'b0;
   logic [16:0] prev_low   = '0;
   int          high_run   = 0;
   int          low_run    = 0;
   int          align_viol = 0;

   always @(negedge FPGA_clock) begin
      if (reset) begin
         high_run   = 0;
         low_run    = 0;
         prev_valid = 1'b0;
      end else begin
         if (tx_pins[16:0] != prev_low && !(prev_clk && !tx_pins[17])) align_viol++;
         if (!prev_clk && tx_pins[17]) begin
            if (tx_pins[16]) begin
               if (!prev_valid) begin
                  chk_eq("gap_low_periods", 32'(low_run >= 2), 32'd1);
                  high_run = 1;
               end else begin
                  high_run++;
               end
               words[wr_cnt[7:0]] = tx_pins[15:0];
               wr_cnt++;
            end else begin
               if (prev_valid) begin
                  chk_eq("valid_high_periods", 32'(high_run), 32'd3);
                  low_run = 1;
               end else begin
                  low_run++;
               end
            end
            prev_valid = tx_pins[16];
         end
      end
      prev_clk = tx_pins[17];
      prev_low = tx_pins[16:0];
   end

   // ---------------- helpers ----------------
   int unsigned rd_idx = 0;

   task automatic tick(input int n);
      repeat (n) @(negedge FPGA_clock);
   endtask

   task automatic expect_frame(input string tag, input logic [15:0] e0,
                               input logic [15:0] e1, input logic [15:0] e2);
      int t = 0;
      while (wr_cnt < rd_idx + 3 && t < 500) begin
         @(negedge FPGA_clock);
         t++;
      end
      if (wr_cnt < rd_idx + 3) begin
         chk_eq({tag, "_timeout"}, wr_cnt - rd_idx, 32'd3);
      end else begin
         chk_eq({tag, "_w0"}, 32'(words[rd_idx[7:0]]), 32'(e0));
         chk_eq({tag, "_w1"}, 32'(words[8'(rd_idx + 1)]), 32'(e1));
         chk_eq({tag, "_w2"}, 32'(words[8'(rd_idx + 2)]), 32'(e2));
         rd_idx += 3;
      end
   endtask

   task automatic wait_idle(input string tag);
      int t = 0;
      while (busy && t < 1000) begin
         @(negedge FPGA_clock);
         t++;
      end
      chk_eq({tag, "_idle"}, 32'(busy), 32'd0);
   endtask

   task automatic count_toggles(input int cycles, output int toggles,
                                output int bad_period, output int nz, output int busy_hi);
      int   last = -1;
      logic pc   = tx_pins[17];
      toggles = 0; bad_period = 0; nz = 0; busy_hi = 0;
      for (int c = 0; c < cycles; c++) begin
         @(negedge FPGA_clock);
         if (tx_pins[17] != pc) begin
            if (last >= 0 && c - last != CLK_HALF) bad_period++;
            last = c;
            toggles++;
            pc = tx_pins[17];
         end
         if (tx_pins[16:0] != 17'd0) nz++;
         if (busy) busy_hi++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- stimulus ----------------
   initial begin
      int toggles, bad_period, nz, busy_hi, lat;
      reset = 1'b1; text_in = '0; text_ready_in = 1'b0;
      audio_in = '0; audio_ready_in = 1'b0;
      tick(3);
      chk_eq("reset_pins", 32'(tx_pins), 32'd0);
      chk_eq("reset_busy", 32'(busy), 32'd0);
      chk_eq("reset_ovf", 32'(text_overflow), 32'd0);
      reset = 1'b0;

      // idle: free-running clock, quiet bus
      count_toggles(100, toggles, bad_period, nz, busy_hi);
      chk_eq("idle_toggles", 32'(toggles), 32'd25);
      chk_eq("idle_period", 32'(bad_period), 32'd0);
      chk_eq("idle_bus_zero", 32'(nz), 32'd0);
      chk_eq("idle_busy", 32'(busy_hi), 32'd0);

      // text only, with latency check
      text_in = 8'h48; text_ready_in = 1'b1;
      @(negedge FPGA_clock);
      text_ready_in = 1'b0;
      chk_eq("busy_after_push", 32'(busy), 32'd1);
      lat = 0;
      while (!tx_pins[16] && lat < 50) begin
         @(negedge FPGA_clock);
         lat++;
      end
      chk_eq("latency", 32'(lat <= 2 * CLK_HALF + 1), 32'd1);
      expect_frame("text_H", 16'h8048, 16'h0000, 16'h0000);
      wait_idle("text_H");

      // audio only, later sample overwrites the earlier one
      audio_in = 32'h11112222; audio_ready_in = 1'b1;
      @(negedge FPGA_clock);
      audio_in = 32'hDEADBEEF;
      @(negedge FPGA_clock);
      audio_ready_in = 1'b0;
      expect_frame("audio", 16'h4000, 16'hDEAD, 16'hBEEF);
      wait_idle("audio");
      tick(60);
      chk_eq("audio_no_extra", wr_cnt - rd_idx, 32'd0);

      // three characters plus one sample
      text_in = 8'h48; text_ready_in = 1'b1;
      audio_in = 32'h12345678; audio_ready_in = 1'b1;
      @(negedge FPGA_clock);
      text_in = 8'h49; audio_ready_in = 1'b0;
      @(negedge FPGA_clock);
      text_in = 8'h4A;
      @(negedge FPGA_clock);
      text_ready_in = 1'b0;
      expect_frame("hij_1", 16'hC048, 16'h1234, 16'h5678);
      expect_frame("hij_2", 16'h8049, 16'h0000, 16'h0000);
      expect_frame("hij_3", 16'h804A, 16'h0000, 16'h0000);
      wait_idle("hij");

      // overflow: ten pushes straight out of reset, before the gap allows a pop
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      rd_idx = wr_cnt;
      for (int i = 0; i < 10; i++) begin
         text_in = 8'(i + 1); text_ready_in = 1'b1;
         @(negedge FPGA_clock);
         chk_eq($sformatf("ovf_push%0d", i + 1), 32'(text_overflow), 32'(i >= 8));
      end
      text_ready_in = 1'b0;
      @(negedge FPGA_clock);
      chk_eq("ovf_after", 32'(text_overflow), 32'd0);
      for (int k = 1; k <= 8; k++)
         expect_frame($sformatf("fifo_%0d", k), 16'h8000 | 16'(k), 16'h0000, 16'h0000);
      wait_idle("fifo");
      tick(60);
      chk_eq("fifo_no_extra", wr_cnt - rd_idx, 32'd0);

      // reset in the middle of a frame
      text_in = 8'h5A; text_ready_in = 1'b1;
      audio_in = 32'hCAFEF00D; audio_ready_in = 1'b1;
      @(negedge FPGA_clock);
      text_in = 8'h59; audio_ready_in = 1'b0;
      @(negedge FPGA_clock);
      text_ready_in = 1'b0;
      lat = 0;
      while (!tx_pins[16] && lat < 100) begin
         @(negedge FPGA_clock);
         lat++;
      end
      tick(2 * CLK_HALF + 1);
      chk_eq("pre_reset_w1", 32'(tx_pins[16:0]), 32'h1CAFE);
      reset = 1'b1;
      @(negedge FPGA_clock);
      chk_eq("reset_mid_frame", 32'(tx_pins), 32'd0);
      tick(4);
      chk_eq("reset_hold", 32'(tx_pins), 32'd0);
      reset = 1'b0;
      rd_idx = wr_cnt;
      count_toggles(80, toggles, bad_period, nz, busy_hi);
      chk_eq("post_reset_toggles", 32'(toggles), 32'd20);
      chk_eq("post_reset_bus_zero", 32'(nz), 32'd0);
      chk_eq("post_reset_busy", 32'(busy_hi), 32'd0);
      chk_eq("post_reset_no_frame", wr_cnt - rd_idx, 32'd0);
      text_in = 8'h41; text_ready_in = 1'b1;
      @(negedge FPGA_clock);
      text_ready_in = 1'b0;
      expect_frame("after_reset", 16'h8041, 16'h0000, 16'h0000);
      wait_idle("after_reset");

      chk_eq("edge_alignment", 32'(align_viol), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
